// File: rtl/arb_mux_rr.sv
// N-channel arbitrating mux: fixed-priority or round-robin grant into a
// one-entry registered output stage with valid/ready on every port.
module arb_mux_rr #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [CW-1:0]         out_ch,
  input  logic                  out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CW-1:0]    out_ch_q, out_ch_d;
  logic [CW-1:0]    last_grant_q, last_grant_d;

  logic             load;
  logic             xfer;
  logic             grant_any;
  logic [CW-1:0]    grant_idx;
  logic [N_CH-1:0]  grant;
  logic [WIDTH-1:0] grant_data;

  assign load = !out_valid_q || out_ready;

  // Both modes share one search loop; fixed priority is round-robin with the
  // pointer pinned at 0, so the order becomes N_CH-1 down to 0.
  always_comb begin : arbitrate
    logic [CW-1:0] idx_c;
    idx_c      = '0;
    grant_any  = 1'b0;
    grant_idx  = '0;
    grant      = '0;
    grant_data = '0;
    for (int k = 1; k <= N_CH; k++) begin
      if (mode) begin
        idx_c = CW'((int'(last_grant_q) + N_CH - k) % N_CH);
      end else begin
        idx_c = CW'(N_CH - k);
      end
      if (!grant_any && in_valid[idx_c]) begin
        grant_any = 1'b1;
        grant_idx = idx_c;
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      if (grant_any && (grant_idx == CW'(i))) begin
        grant[i]   = 1'b1;
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign in_ready = grant & {N_CH{load}};
  assign xfer     = grant_any && load;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_ch_d     = out_ch_q;
    last_grant_d = last_grant_q;
    if (load) begin
      out_valid_d = grant_any;
    end
    if (xfer) begin
      out_data_d   = grant_data;
      out_ch_d     = grant_idx;
      last_grant_d = grant_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_ch_q     <= '0;
      last_grant_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: doc/arb_mux_rr.md
Name: arb_mux_rr

Overview:
- Parametrised N-channel arbitrating multiplexer with a registered output and valid/ready handshakes on every port.
- Generalises the 4-input, 4-bit priority select to N_CH channels of WIDTH bits.
- Adds a runtime choice between fixed priority and round-robin, output backpressure, and a one-entry output register.
- Used wherever several producers share one downstream consumer.

Parameters:
- N_CH, 4, number of input channels (>=2).
- WIDTH, 4, data width per channel (>=1).
- CW, $clog2(N_CH), channel-index width (derived; do not override).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = fixed priority, 1 = round-robin.
- in_valid  in  N_CH  per-channel request; bit i belongs to channel i.
- in_data  in  N_CH*WIDTH  flattened data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  out  N_CH  per-channel accept; one-hot or zero.
- out_valid  out  1  output register holds data.
- out_data  out  WIDTH  registered data of the granted channel.
- out_ch  out  CW  index of the channel that produced out_data.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_ch=0, last_grant=0. Reset mid-transfer discards the held word and any pending accept.
- Load enable: load = !out_valid || out_ready.
  - Throughput is 1 word/cycle.
  - Latency from input accept to out_valid is 1 cycle.
- Arbitration is combinational from in_valid, mode and last_grant. At most one grant per cycle.
- in_ready[i] = grant[i] && load.
  - in_ready must not depend on in_valid of the same channel except through arbitration.
  - No in_ready when load=0.
- Transfer on channel i when in_valid[i] && in_ready[i]. At the next edge:
  - out_data <= channel i data, out_ch <= i, out_valid <= 1, last_grant <= i.
- Drain without refill: out_valid && out_ready && no grant -> out_valid <= 0. out_data and out_ch hold their last values.
- Hold under backpressure: out_valid && !out_ready -> out_valid, out_data and out_ch stable.
- Fixed mode: highest index wins, so channel N_CH-1 has highest priority and channel 0 lowest. Lower channels may starve.
- Round-robin mode:
  - Search order is last_grant-1, last_grant-2, … (mod N_CH), ending at last_grant. The last winner has lowest priority.
  - After reset (last_grant=0) the search order is N_CH-1 … 0, identical to fixed priority.
- last_grant updates on every transfer in either mode. A mode switch applies to the arbitration of the same cycle; no state is flushed.
- No in_valid set -> grant=0, last_grant unchanged.
- Input protocol: once asserted, in_valid/in_data must be held until accepted. The block does not check this.
- Non-power-of-two N_CH: indices >= N_CH never occur; wrap is modulo N_CH, not 2^CW.

Test Plan (N_CH=4, WIDTH=4, data ch0..ch3 = 4'h1,4'h2,4'h3,4'h4 unless stated):
- Reset check: rst_n=0 asynchronously mid-cycle with out_valid=1 -> out_valid=0, out_data=0, out_ch=0 immediately. After release with in_valid=0: in_ready=0000, out_valid stays 0.
- Fixed priority: mode=0, in_valid=0110, ch1=4'h5, ch2=4'hA, out_ready=1 -> in_ready=0100. Next cycle out_valid=1, out_data=4'hA, out_ch=2. With ch2 re-presenting, ch1 never granted.
- Round-robin fairness: mode=1, in_valid=1111 held, out_ready=1 from reset -> out_ch sequence 3,2,1,0,3,2 on consecutive cycles. out_data sequence 4,3,2,1,4,3.
- Round-robin skip: mode=1, last_grant=2, in_valid=0101 -> ch0 granted (search 1,0). Next cycle ch2 granted (search 3,2).
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with in_valid=1111 -> in_ready=0000, out_data/out_ch unchanged. out_ready=1 -> same-cycle refill, new word next cycle, no bubble.
- Drain/idle: out_valid=1, out_ready=1, in_valid=0000 -> out_valid=0 next cycle, last_grant unchanged. Later single request in_valid=0001 -> in_ready=0001, out_ch=0.
